logic_stream_unit: RTL
======================

Name: logic_stream_unit

Overview:
- Parametrised successor to the single-bit AND cell: a WIDTH-bit bitwise logic unit with 8 selectable operations and a valid/ready stream interface.
- Two modes: elementwise (one result per input beat) and accumulate (folds a multi-beat packet into one result on the last beat).
- Sits between the pad-level input wrapper and the output pins of a tile; the output register drives uo_out directly.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1).
- CNT_W, 8, width of the beat counter reported with each result (>=1).

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  input beat valid
- in_ready  output  1  unit can accept a beat this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B; used only in elementwise mode
- in_op  input  3  operation select
- in_mode  input  1  0 = elementwise, 1 = accumulate
- in_last  input  1  last beat of an accumulate packet; ignored in elementwise mode
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  WIDTH  result
- out_zero  output  1  out_data == 0
- out_count  output  CNT_W  beats folded into this result (saturating)

Behaviour:
- Reset: one clock, synchronous, active-high. Clock is clk; reset is rst. While rst=1 at a clock edge:
  - out_valid=0, out_data=0, out_zero=1, out_count=0.
  - Accumulator=0, beat counter=0, state=IDLE.
  - A partial packet is discarded.
- Ops f(x,y): 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 pass x, 111 NOT x.
- Handshake:
  - A beat transfers when in_valid && in_ready.
  - A result transfers when out_valid && out_ready.
  - in_ready = !out_valid || out_ready (combinational; single output register, no skid).
  - out_valid, out_data, out_zero and out_count stay stable while out_valid && !out_ready.
- FSM states IDLE and ACCUM.
- IDLE, beat with in_mode=0:
  - Next cycle: out_data=f(in_a,in_b), out_count=1, out_valid=1. Latency is 1 cycle.
  - State stays IDLE.
- IDLE, beat with in_mode=1:
  - Latch in_op as pkt_op. acc<=in_a, cnt<=1.
  - If in_last=1: emit acc=in_a, count 1 next cycle (single-beat packet); stay IDLE.
  - Else go to ACCUM.
- ACCUM, any beat:
  - acc<=f(acc,in_a) using pkt_op. cnt<=cnt+1, saturating at 2^CNT_W-1.
  - in_mode, in_op and in_b are ignored.
  - If in_last=1: the next cycle out_data=f(acc,in_a) and out_count=the saturated count, out_valid=1; go to IDLE.
- A result may be loaded in the same cycle the previous result is taken (out_ready=1). Full throughput is 1 beat/cycle.
- No beat is accepted while the output register is full and not draining. This holds in ACCUM too, so a beat is never dropped.
- out_zero is registered with out_data.
- Simultaneous rst and a transfer: rst wins and nothing is recorded.

Optional Feature:
- Macro LOGIC_STREAM_PARITY_EN.
- Defined: extra port out_parity (output, 1), registered with out_data, equal to the XOR-reduction of out_data. Reset value 0.
- Not defined: port absent and no parity logic; all other behaviour is identical.

Test Plan:
- Reset then idle, WIDTH=8: hold rst=1 two cycles -> out_valid=0, out_data=0x00, out_zero=1, out_count=0, in_ready=1.
- Elementwise sweep: a=0xF0, b=0x3C, ops 000..111 back-to-back with out_ready=1 -> out_data 0x30, 0xFC, 0xCC, 0xCF, 0x03, 0x33, 0xF0, 0x0F on consecutive cycles, each 1 cycle after its beat, out_count=1.
- Accumulate AND: 3 beats a=0xFF, 0x7E, 0x3C, op=000, in_last on the third beat -> single result 0x3C, out_count=3. in_op changed mid-packet to 001 has no effect.
- Backpressure: out_ready=0 with a result pending -> in_ready=0, outputs stable for 5 cycles. Raise out_ready -> result taken and the next beat accepted in the same cycle.
- Reset mid-packet: 2 accumulate beats, then rst=1 -> no result emitted. A following elementwise XOR beat a=0xAA, b=0xAA -> out_data=0x00, out_zero=1.
- Counter saturation, CNT_W=2: 6-beat XOR packet a=0x01 each beat -> out_data=0x00, out_count=3. With LOGIC_STREAM_PARITY_EN defined, out_parity=0; a 5-beat packet gives 0x01 and out_parity=1.

Source files
------------

// File: rtl/logic_stream_unit_if.sv
// Stream interface for logic_stream_unit: input beat channel and result channel.
// Optional out_parity signal is present when LOGIC_STREAM_PARITY_EN is defined.
interface logic_stream_unit_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [2:0]       in_op;
   logic             in_mode;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_zero;
   logic [CNT_W-1:0] out_count;
`ifdef LOGIC_STREAM_PARITY_EN
   logic             out_parity;
`endif

   // Producer side: drives beats, consumes results
   modport master (
      output in_valid, in_a, in_b, in_op, in_mode, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_zero, out_count
`ifdef LOGIC_STREAM_PARITY_EN
      , input out_parity
`endif
   );

   // Unit side: accepts beats, produces results
   modport slave (
      input  in_valid, in_a, in_b, in_op, in_mode, in_last, out_ready,
      output in_ready, out_valid, out_data, out_zero, out_count
`ifdef LOGIC_STREAM_PARITY_EN
      , output out_parity
`endif
   );
endinterface

// File: rtl/logic_stream_unit.sv
// logic_stream_unit: WIDTH-bit bitwise logic unit with 8 operations, elementwise
// and accumulate (packet fold) modes, valid/ready stream on both sides.
// Optional macro LOGIC_STREAM_PARITY_EN adds a registered out_parity output.
module logic_stream_unit #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 8
) (
   input logic                clk,
   input logic                rst,
   logic_stream_unit_if.slave s
);

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       pkt_op_q, pkt_op_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_zero_q, out_zero_d;
   logic [CNT_W-1:0] out_count_q, out_count_d;
`ifdef LOGIC_STREAM_PARITY_EN
   logic             out_parity_q, out_parity_d;
`endif

   logic             in_fire;
   logic             out_fire;
   logic [WIDTH-1:0] fold_val;
   logic [CNT_W-1:0] cnt_inc;

   function automatic logic [WIDTH-1:0] f_op(input logic [2:0] op,
                                             input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
      case (op)
         3'b000:  return x & y;
         3'b001:  return x | y;
         3'b010:  return x ^ y;
         3'b011:  return ~(x & y);
         3'b100:  return ~(x | y);
         3'b101:  return ~(x ^ y);
         3'b110:  return x;
         default: return ~x;
      endcase
   endfunction

   // Single output register: accept a beat whenever it is empty or being drained
   assign s.in_ready = !out_valid_q || s.out_ready;
   assign in_fire    = s.in_valid && s.in_ready;
   assign out_fire   = out_valid_q && s.out_ready;

   assign fold_val   = f_op(pkt_op_q, acc_q, s.in_a);
   assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

   // Next-state, accumulator and result-register update
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      pkt_op_d    = pkt_op_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_count_d = out_count_q;
      if (out_fire) out_valid_d = 1'b0;
      if (in_fire) begin
         case (state_q)
            IDLE: begin
               if (!s.in_mode) begin
                  out_valid_d = 1'b1;
                  out_data_d  = f_op(s.in_op, s.in_a, s.in_b);
                  out_count_d = CNT_W'(1);
               end else begin
                  pkt_op_d = s.in_op;
                  acc_d    = s.in_a;
                  cnt_d    = CNT_W'(1);
                  if (s.in_last) begin
                     out_valid_d = 1'b1;
                     out_data_d  = s.in_a;
                     out_count_d = CNT_W'(1);
                  end else begin
                     state_d = ACCUM;
                  end
               end
            end
            default: begin
               acc_d = fold_val;
               cnt_d = cnt_inc;
               if (s.in_last) begin
                  out_valid_d = 1'b1;
                  out_data_d  = fold_val;
                  out_count_d = cnt_inc;
                  state_d     = IDLE;
               end
            end
         endcase
      end
      // Derived flags track out_data_d, so they only change when a result loads
      out_zero_d = (out_data_d == '0);
`ifdef LOGIC_STREAM_PARITY_EN
      out_parity_d = ^out_data_d;
`endif
   end

   // State and result registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         pkt_op_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_zero_q  <= 1'b1;
         out_count_q <= '0;
`ifdef LOGIC_STREAM_PARITY_EN
         out_parity_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         pkt_op_q    <= pkt_op_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_zero_q  <= out_zero_d;
         out_count_q <= out_count_d;
`ifdef LOGIC_STREAM_PARITY_EN
         out_parity_q <= out_parity_d;
`endif
      end
   end

   assign s.out_valid = out_valid_q;
   assign s.out_data  = out_data_q;
   assign s.out_zero  = out_zero_q;
   assign s.out_count = out_count_q;
`ifdef LOGIC_STREAM_PARITY_EN
   assign s.out_parity = out_parity_q;
`endif

endmodule
